// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared encodings and instruction field layout for the sequencer
package cu_pkg;
    localparam int IR_W_DEF    = 9;
    localparam int PC_W_DEF    = 5;
    localparam int TIMEOUT_DEF = 15;

    localparam int CMD_LSB  = 6;
    localparam int ADR1_LSB = 3;
    localparam int ADR2_LSB = 0;

    localparam logic [2:0] CMD_HALT = 3'b111;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_HALTED = ST_HALTED,
        S_ERR    = ST_ERR
    } state_t;
endpackage

// File: rtl/cu_if.sv
// rtl/cu_if.sv - instruction memory and control-FSM issue/done bundle
interface cu_if
    import cu_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int IR_W = IR_W_DEF
);
    logic [PC_W-1:0] imem_addr;
    logic [IR_W-1:0] imem_rdata;
    logic [IR_W-1:0] ir;
    logic            ir_valid;
    logic            cu_done;

    modport master (
        output imem_addr, ir, ir_valid,
        input  imem_rdata, cu_done
    );

    modport slave (
        input  imem_addr, ir, ir_valid,
        output imem_rdata, cu_done
    );
endinterface

// File: rtl/cu_watchdog.sv
// rtl/cu_watchdog.sv - counts EXEC cycles and flags a missing done on the last allowed cycle
module cu_watchdog
    import cu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    input  logic done,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);

    // cnt_q holds completed EXEC cycles, so the current cycle number is cnt_q+1
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != CW'(TIMEOUT))) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expire = en && !done && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/cu_sequencer.sv
// rtl/cu_sequencer.sv - program counter, fetch/issue FSM and retire counter for the control FSM
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int IR_W    = IR_W_DEF,
    parameter int PC_W    = PC_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            Resetn,
    input  logic            run,
    input  logic            step,
    input  logic            halt_req,
    input  logic            pc_load,
    input  logic [PC_W-1:0] pc_load_val,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            err_timeout,
    output logic [15:0]     instr_count,
    cu_if.master            bus
);
    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [IR_W-1:0] ir_q;
    logic            ir_valid_q;
    logic            busy_q;
    logic            halted_q;
    logic            err_q;
    logic            step_mode_q;
    logic [15:0]     count_q;
    logic            wd_expire;

    cu_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst_n  (Resetn),
        .clear  (state_q == S_DECODE),
        .en     (state_q == S_EXEC),
        .done   (bus.cu_done),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
            step_mode_q <= 1'b0;
            count_q     <= '0;
        end else begin
            ir_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pc_load) begin
                        pc_q <= pc_load_val;
                    end else if (run || step) begin
                        state_q     <= S_FETCH;
                        step_mode_q <= !run;
                        busy_q      <= 1'b1;
                    end
                end
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    ir_q <= bus.imem_rdata;
                    if (bus.imem_rdata[CMD_LSB +: 3] == CMD_HALT) begin
                        state_q  <= S_HALTED;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        state_q    <= S_EXEC;
                        ir_valid_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    // done on the final watchdog cycle still retires
                    if (bus.cu_done) begin
                        pc_q <= pc_q + 1'b1;
                        if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
                        if (halt_req) begin
                            state_q  <= S_HALTED;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                        end else if (step_mode_q || !run) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end else if (wd_expire) begin
                        state_q <= S_ERR;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (pc_load) pc_q <= pc_load_val;
                    // resume needs run to fall first so a held run cannot re-hit HALT
                    if (!run) begin
                        state_q  <= S_IDLE;
                        halted_q <= 1'b0;
                    end
                end
                S_ERR: state_q <= S_ERR;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.ir        = ir_q;
    assign bus.ir_valid  = ir_valid_q;
    assign pc            = pc_q;
    assign busy          = busy_q;
    assign halted        = halted_q;
    assign err_timeout   = err_q;
    assign instr_count   = count_q;
endmodule
